// File: rtl/mcb_port_responder.sv
// Behavioural responder for one MCB user port: command/write/read FIFOs in front of
// a 64-bit word store, sequenced by a small command-execution FSM.
module mcb_port_responder #(
  parameter int ADDR_WIDTH   = 8,
  parameter int CALIB_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  output logic        c3_calib_done,
  input  logic        c3_p0_cmd_en,
  input  logic [2:0]  c3_p0_cmd_instr,
  input  logic [5:0]  c3_p0_cmd_bl,
  input  logic [29:0] c3_p0_cmd_byte_addr,
  output logic        c3_p0_cmd_empty,
  output logic        c3_p0_cmd_full,
  input  logic        c3_p0_wr_en,
  input  logic [7:0]  c3_p0_wr_mask,
  input  logic [63:0] c3_p0_wr_data,
  output logic        c3_p0_wr_full,
  output logic        c3_p0_wr_empty,
  output logic [6:0]  c3_p0_wr_count,
  output logic        c3_p0_wr_underrun,
  output logic        c3_p0_wr_error,
  input  logic        c3_p0_rd_en,
  output logic [63:0] c3_p0_rd_data,
  output logic        c3_p0_rd_full,
  output logic        c3_p0_rd_empty,
  output logic [6:0]  c3_p0_rd_count,
  output logic        c3_p0_rd_error
);
  localparam int CW    = $clog2(CALIB_CYCLES + 1);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_READ_DRAIN} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [5:0]            beat_q;
  logic [CW-1:0]         calib_cnt_q;
  logic                  calib_q;

  logic [2:0]            cmd_instr_mem [4];
  logic [5:0]            cmd_bl_mem    [4];
  logic [ADDR_WIDTH-1:0] cmd_addr_mem  [4];
  logic [1:0]            cmd_wp_q, cmd_rp_q;
  logic [2:0]            cmd_cnt_q;

  logic [71:0]           wr_mem [64];
  logic [5:0]            wr_wp_q, wr_rp_q;
  logic [6:0]            wr_cnt_q;

  logic [63:0]           rd_mem [64];
  logic [5:0]            rd_wp_q, rd_rp_q;
  logic [6:0]            rd_cnt_q;

  logic [63:0]           store [DEPTH];
  logic [63:0]           store_rd_q;
  logic                  rd_vld_q;
  logic                  wr_err_q, rd_err_q;

  logic                  cmd_push, cmd_pop, wr_push, wr_pop, rd_issue, rd_pop;
  logic [71:0]           wr_head;
  logic [63:0]           wr_merged;
  logic                  unused_addr_bits;

  assign cmd_push = c3_p0_cmd_en && calib_q && (cmd_cnt_q != 3'd4);
  assign cmd_pop  = (state_q == S_IDLE) && (cmd_cnt_q != 3'd0);
  assign wr_push  = c3_p0_wr_en && (wr_cnt_q != 7'd64);
  assign wr_pop   = (state_q == S_WRITE) && (wr_cnt_q != 7'd0);
  assign rd_pop   = c3_p0_rd_en && (rd_cnt_q != 7'd0);
  // The in-flight store read already owns a read FIFO slot.
  assign rd_issue = (state_q == S_READ) && ((rd_cnt_q + 7'(rd_vld_q)) < 7'd64);
  assign wr_head  = wr_mem[wr_rp_q];

  assign unused_addr_bits = ^{c3_p0_cmd_byte_addr[2:0], c3_p0_cmd_byte_addr[29:ADDR_WIDTH+3]};

  always_comb begin
    wr_merged = store[addr_q];
    for (int b = 0; b < 8; b++) begin
      if (!wr_head[64+b]) wr_merged[8*b +: 8] = wr_head[8*b +: 8];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      calib_cnt_q <= CW'(CALIB_CYCLES);
      calib_q     <= 1'b0;
    end else begin
      if (calib_cnt_q != '0) calib_cnt_q <= calib_cnt_q - CW'(1);
      calib_q <= calib_q | (calib_cnt_q == '0);
    end
  end

  // Storage arrays carry no reset; only pointers and counts are flushed.
  always_ff @(posedge clock) begin
    if (cmd_push) begin
      cmd_instr_mem[cmd_wp_q] <= c3_p0_cmd_instr;
      cmd_bl_mem[cmd_wp_q]    <= c3_p0_cmd_bl;
      cmd_addr_mem[cmd_wp_q]  <= c3_p0_cmd_byte_addr[ADDR_WIDTH+2:3];
    end
    if (wr_push)  wr_mem[wr_wp_q]  <= {c3_p0_wr_mask, c3_p0_wr_data};
    if (rd_vld_q) rd_mem[rd_wp_q]  <= store_rd_q;
    if (wr_pop)   store[addr_q]    <= wr_merged;
    if (rd_issue) store_rd_q       <= store[addr_q];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cmd_wp_q <= '0; cmd_rp_q <= '0; cmd_cnt_q <= '0;
      wr_wp_q  <= '0; wr_rp_q  <= '0; wr_cnt_q  <= '0;
      rd_wp_q  <= '0; rd_rp_q  <= '0; rd_cnt_q  <= '0;
      rd_vld_q <= 1'b0;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      if (cmd_push) cmd_wp_q <= cmd_wp_q + 2'd1;
      if (cmd_pop)  cmd_rp_q <= cmd_rp_q + 2'd1;
      cmd_cnt_q <= cmd_cnt_q + 3'(cmd_push) - 3'(cmd_pop);
      if (wr_push)  wr_wp_q <= wr_wp_q + 6'd1;
      if (wr_pop)   wr_rp_q <= wr_rp_q + 6'd1;
      wr_cnt_q <= wr_cnt_q + 7'(wr_push) - 7'(wr_pop);
      if (rd_vld_q) rd_wp_q <= rd_wp_q + 6'd1;
      if (rd_pop)   rd_rp_q <= rd_rp_q + 6'd1;
      rd_cnt_q <= rd_cnt_q + 7'(rd_vld_q) - 7'(rd_pop);
      rd_vld_q <= rd_issue;
      wr_err_q <= wr_err_q | (c3_p0_wr_en && !wr_push) | c3_p0_wr_underrun;
      rd_err_q <= rd_err_q | (c3_p0_rd_en && !rd_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      beat_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (cmd_pop) begin
          addr_q <= cmd_addr_mem[cmd_rp_q];
          beat_q <= cmd_bl_mem[cmd_rp_q];
          case (cmd_instr_mem[cmd_rp_q])
            3'b000:  state_q <= S_WRITE;
            3'b001:  state_q <= S_READ;
            default: state_q <= S_IDLE;
          endcase
        end
        S_WRITE: if (wr_pop) begin
          addr_q <= addr_q + ADDR_WIDTH'(1);
          if (beat_q == 6'd0) state_q <= S_IDLE;
          else                beat_q  <= beat_q - 6'd1;
        end
        S_READ: if (rd_issue) begin
          addr_q <= addr_q + ADDR_WIDTH'(1);
          if (beat_q == 6'd0) state_q <= S_READ_DRAIN;
          else                beat_q  <= beat_q - 6'd1;
        end
        // The last issued word is pushed on this same edge.
        S_READ_DRAIN: state_q <= S_IDLE;
        default:      state_q <= S_IDLE;
      endcase
    end
  end

  assign c3_calib_done     = calib_q;
  assign c3_p0_cmd_empty   = (cmd_cnt_q == 3'd0);
  assign c3_p0_cmd_full    = (cmd_cnt_q == 3'd4);
  assign c3_p0_wr_empty    = (wr_cnt_q == 7'd0);
  assign c3_p0_wr_full     = (wr_cnt_q == 7'd64);
  assign c3_p0_wr_count    = wr_cnt_q;
  assign c3_p0_wr_underrun = (state_q == S_WRITE) && (wr_cnt_q == 7'd0);
  assign c3_p0_wr_error    = wr_err_q;
  assign c3_p0_rd_empty    = (rd_cnt_q == 7'd0);
  assign c3_p0_rd_full     = (rd_cnt_q == 7'd64);
  assign c3_p0_rd_count    = rd_cnt_q;
  assign c3_p0_rd_data     = (rd_cnt_q == 7'd0) ? 64'd0 : rd_mem[rd_rp_q];
  assign c3_p0_rd_error    = rd_err_q;
endmodule

// File: tb/tb_mcb_port_responder.sv
// Scoreboard bench for mcb_port_responder: a bench-side word store predicts read data,
// queued at read-command time and compared as words are popped.
module tb_mcb_port_responder;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        c3_calib_done;
  logic        c3_p0_cmd_en = 1'b0;
  logic [2:0]  c3_p0_cmd_instr = '0;
  logic [5:0]  c3_p0_cmd_bl = '0;
  logic [29:0] c3_p0_cmd_byte_addr = '0;
  logic        c3_p0_cmd_empty, c3_p0_cmd_full;
  logic        c3_p0_wr_en = 1'b0;
  logic [7:0]  c3_p0_wr_mask = '0;
  logic [63:0] c3_p0_wr_data = '0;
  logic        c3_p0_wr_full, c3_p0_wr_empty;
  logic [6:0]  c3_p0_wr_count;
  logic        c3_p0_wr_underrun, c3_p0_wr_error;
  logic        c3_p0_rd_en = 1'b0;
  logic [63:0] c3_p0_rd_data;
  logic        c3_p0_rd_full, c3_p0_rd_empty;
  logic [6:0]  c3_p0_rd_count;
  logic        c3_p0_rd_error;

  int errors = 0;
  int checks = 0;
  logic [63:0] model [256];
  logic [63:0] exp_q [$];

  mcb_port_responder #(.ADDR_WIDTH(8), .CALIB_CYCLES(16)) dut (
    .clock(clock), .reset(reset), .c3_calib_done(c3_calib_done),
    .c3_p0_cmd_en(c3_p0_cmd_en), .c3_p0_cmd_instr(c3_p0_cmd_instr),
    .c3_p0_cmd_bl(c3_p0_cmd_bl), .c3_p0_cmd_byte_addr(c3_p0_cmd_byte_addr),
    .c3_p0_cmd_empty(c3_p0_cmd_empty), .c3_p0_cmd_full(c3_p0_cmd_full),
    .c3_p0_wr_en(c3_p0_wr_en), .c3_p0_wr_mask(c3_p0_wr_mask), .c3_p0_wr_data(c3_p0_wr_data),
    .c3_p0_wr_full(c3_p0_wr_full), .c3_p0_wr_empty(c3_p0_wr_empty), .c3_p0_wr_count(c3_p0_wr_count),
    .c3_p0_wr_underrun(c3_p0_wr_underrun), .c3_p0_wr_error(c3_p0_wr_error),
    .c3_p0_rd_en(c3_p0_rd_en), .c3_p0_rd_data(c3_p0_rd_data),
    .c3_p0_rd_full(c3_p0_rd_full), .c3_p0_rd_empty(c3_p0_rd_empty),
    .c3_p0_rd_count(c3_p0_rd_count), .c3_p0_rd_error(c3_p0_rd_error)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_wr(input logic [7:0] m, input logic [63:0] d);
    c3_p0_wr_mask = m; c3_p0_wr_data = d; c3_p0_wr_en = 1'b1;
    tick();
    c3_p0_wr_en = 1'b0;
  endtask

  task automatic send_cmd(input logic [2:0] instr, input logic [5:0] bl, input logic [29:0] ba);
    c3_p0_cmd_instr = instr; c3_p0_cmd_bl = bl; c3_p0_cmd_byte_addr = ba; c3_p0_cmd_en = 1'b1;
    tick();
    c3_p0_cmd_en = 1'b0;
  endtask

  task automatic model_write(input int wa, input logic [7:0] m, input logic [63:0] d);
    for (int b = 0; b < 8; b++)
      if (!m[b]) model[wa % 256][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic expect_read(input int wa, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(model[(wa + i) % 256]);
  endtask

  task automatic drain(input int n, input string tag);
    logic [63:0] exp;
    for (int i = 0; i < n; i++) begin
      int t = 0;
      while (c3_p0_rd_empty && t < 100) begin tick(); t++; end
      checks++;
      if (c3_p0_rd_empty) begin
        errors++;
        $display("FAIL %s: word %0d never arrived (rd_empty=%b, need 0)", tag, i, c3_p0_rd_empty);
        return;
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s: unexpected word %h, no expectation queued", tag, c3_p0_rd_data);
      end else begin
        exp = exp_q.pop_front();
        if (c3_p0_rd_data !== exp) begin
          errors++;
          $display("FAIL %s word %0d: got %h expected %h", tag, i, c3_p0_rd_data, exp);
        end
      end
      c3_p0_rd_en = 1'b1;
      tick();
      c3_p0_rd_en = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [9:0] flags;
    reset = 1'b1;
    repeat (3) tick();
    flags = {c3_p0_cmd_empty, c3_p0_cmd_full, c3_p0_wr_empty, c3_p0_wr_full, c3_p0_rd_empty,
             c3_p0_rd_full, c3_p0_wr_underrun, c3_p0_wr_error, c3_p0_rd_error, c3_calib_done};
    checks++;
    if (flags !== 10'b1010100000) begin
      errors++; $display("FAIL reset_flags: got %b expected 1010100000", flags);
    end
    checks++;
    if (c3_p0_wr_count !== 7'd0 || c3_p0_rd_count !== 7'd0) begin
      errors++; $display("FAIL reset_counts: wr=%0d rd=%0d expected 0/0", c3_p0_wr_count, c3_p0_rd_count);
    end
    checks++;
    if (c3_p0_rd_data !== 64'd0) begin
      errors++; $display("FAIL reset_rd_data: got %h expected 0", c3_p0_rd_data);
    end
  endtask

  task automatic test_calib();
    reset = 1'b0;
    send_cmd(3'b001, 6'd0, 30'h0);
    checks++;
    if (c3_p0_cmd_empty !== 1'b1) begin
      errors++; $display("FAIL calib_cmd_ignored: cmd_empty=%b expected 1", c3_p0_cmd_empty);
    end
    repeat (15) tick();
    checks++;
    if (c3_calib_done !== 1'b0) begin
      errors++; $display("FAIL calib_early: calib_done=%b after 15 cycles, expected 0", c3_calib_done);
    end
    tick();
    checks++;
    if (c3_calib_done !== 1'b1) begin
      errors++; $display("FAIL calib_on_time: calib_done=%b after 16 cycles, expected 1", c3_calib_done);
    end
    checks++;
    if (c3_p0_cmd_empty !== 1'b1 || c3_p0_rd_empty !== 1'b1) begin
      errors++; $display("FAIL calib_no_cmd: cmd_empty=%b rd_empty=%b expected 1/1", c3_p0_cmd_empty, c3_p0_rd_empty);
    end
  endtask

  task automatic test_burst();
    int t;
    for (int i = 0; i < 64; i++) begin
      push_wr(8'h00, 64'(i));
      model_write(i, 8'h00, 64'(i));
    end
    checks++;
    if (c3_p0_wr_count !== 7'd64 || c3_p0_wr_full !== 1'b1) begin
      errors++; $display("FAIL burst_wr_fill: count=%0d full=%b expected 64/1", c3_p0_wr_count, c3_p0_wr_full);
    end
    send_cmd(3'b000, 6'd63, 30'h0);
    t = 0;
    while (!c3_p0_wr_empty && t < 200) begin tick(); t++; end
    checks++;
    if (c3_p0_wr_empty !== 1'b1 || c3_p0_wr_error !== 1'b0) begin
      errors++; $display("FAIL burst_write_done: wr_empty=%b wr_error=%b expected 1/0", c3_p0_wr_empty, c3_p0_wr_error);
    end
    expect_read(0, 64);
    send_cmd(3'b001, 6'd63, 30'h0);
    tick(); tick();
    checks++;
    if (c3_p0_rd_empty !== 1'b1) begin
      errors++; $display("FAIL burst_latency_early: rd_empty=%b two edges after cmd, expected 1", c3_p0_rd_empty);
    end
    tick();
    checks++;
    if (c3_p0_rd_empty !== 1'b0) begin
      errors++; $display("FAIL burst_latency: rd_empty=%b three edges after cmd, expected 0", c3_p0_rd_empty);
    end
    t = 0;
    while (c3_p0_rd_count !== 7'd64 && t < 200) begin tick(); t++; end
    checks++;
    if (c3_p0_rd_count !== 7'd64 || c3_p0_rd_full !== 1'b1) begin
      errors++; $display("FAIL burst_rd_fill: count=%0d full=%b expected 64/1", c3_p0_rd_count, c3_p0_rd_full);
    end
    drain(64, "burst");
    checks++;
    if (c3_p0_rd_empty !== 1'b1 || c3_p0_rd_count !== 7'd0) begin
      errors++; $display("FAIL burst_drained: empty=%b count=%0d expected 1/0", c3_p0_rd_empty, c3_p0_rd_count);
    end
  endtask

  task automatic test_masked();
    push_wr(8'h00, 64'h1111111111111111);
    model_write(5, 8'h00, 64'h1111111111111111);
    send_cmd(3'b000, 6'd0, 30'h28);
    push_wr(8'h0F, 64'hFFFFFFFFFFFFFFFF);
    model_write(5, 8'h0F, 64'hFFFFFFFFFFFFFFFF);
    send_cmd(3'b000, 6'd0, 30'h28);
    // High and low address bits are junk here and must be ignored.
    exp_q.push_back(64'hFFFFFFFF11111111);
    send_cmd(3'b001, 6'd0, 30'h2000_082F);
    drain(1, "masked");
  endtask

  task automatic test_errors_backpressure();
    int t;
    checks++;
    if (c3_p0_rd_error !== 1'b0) begin
      errors++; $display("FAIL rd_error_pre: got %b expected 0", c3_p0_rd_error);
    end
    c3_p0_rd_en = 1'b1; tick(); c3_p0_rd_en = 1'b0;
    checks++;
    if (c3_p0_rd_error !== 1'b1 || c3_p0_rd_count !== 7'd0) begin
      errors++; $display("FAIL rd_error_empty_pop: err=%b count=%0d expected 1/0", c3_p0_rd_error, c3_p0_rd_count);
    end
    for (int i = 0; i < 64; i++) push_wr(8'h00, 64'hDEAD_0000 + 64'(i));
    checks++;
    if (c3_p0_wr_count !== 7'd64 || c3_p0_wr_full !== 1'b1 || c3_p0_wr_error !== 1'b0) begin
      errors++; $display("FAIL wr_fill: count=%0d full=%b err=%b expected 64/1/0",
                         c3_p0_wr_count, c3_p0_wr_full, c3_p0_wr_error);
    end
    push_wr(8'h00, 64'hBAD);
    checks++;
    if (c3_p0_wr_error !== 1'b1 || c3_p0_wr_count !== 7'd64) begin
      errors++; $display("FAIL wr_overflow: err=%b count=%0d expected 1/64", c3_p0_wr_error, c3_p0_wr_count);
    end
    expect_read(0, 64);
    send_cmd(3'b001, 6'd63, 30'h0);
    t = 0;
    while (c3_p0_rd_count !== 7'd64 && t < 200) begin tick(); t++; end
    repeat (5) tick();
    checks++;
    if (c3_p0_rd_count !== 7'd64 || c3_p0_rd_full !== 1'b1) begin
      errors++; $display("FAIL rd_backpressure: count=%0d full=%b expected 64/1", c3_p0_rd_count, c3_p0_rd_full);
    end
    drain(64, "backpressure");
  endtask

  task automatic test_reset_midread();
    logic [9:0] flags;
    int t;
    send_cmd(3'b001, 6'd63, 30'h0);
    repeat (10) tick();
    checks++;
    if (c3_p0_rd_empty !== 1'b0) begin
      errors++; $display("FAIL midread_active: rd_empty=%b expected 0", c3_p0_rd_empty);
    end
    reset = 1'b1;
    tick();
    exp_q.delete();
    flags = {c3_p0_cmd_empty, c3_p0_cmd_full, c3_p0_wr_empty, c3_p0_wr_full, c3_p0_rd_empty,
             c3_p0_rd_full, c3_p0_wr_underrun, c3_p0_wr_error, c3_p0_rd_error, c3_calib_done};
    checks++;
    if (flags !== 10'b1010100000) begin
      errors++; $display("FAIL midread_reset_flags: got %b expected 1010100000", flags);
    end
    checks++;
    if (c3_p0_wr_count !== 7'd0 || c3_p0_rd_count !== 7'd0 || c3_p0_rd_data !== 64'd0) begin
      errors++; $display("FAIL midread_reset_counts: wr=%0d rd=%0d data=%h expected 0/0/0",
                         c3_p0_wr_count, c3_p0_rd_count, c3_p0_rd_data);
    end
    reset = 1'b0;
    t = 0;
    while (!c3_calib_done && t < 40) begin tick(); t++; end
    checks++;
    if (c3_calib_done !== 1'b1 || c3_p0_rd_count !== 7'd0) begin
      errors++; $display("FAIL recalib: calib=%b rd_count=%0d expected 1/0", c3_calib_done, c3_p0_rd_count);
    end
    exp_q.push_back(64'hFFFFFFFF11111111);
    send_cmd(3'b001, 6'd0, 30'h28);
    drain(1, "store_persist");
  endtask

  task automatic test_underrun_wrap();
    int t;
    logic [63:0] d [4];
    for (int i = 0; i < 4; i++) d[i] = 64'hA5A5_0000_0000_0000 + 64'(i * 3 + 1);
    checks++;
    if (c3_p0_wr_error !== 1'b0) begin
      errors++; $display("FAIL underrun_pre: wr_error=%b expected 0", c3_p0_wr_error);
    end
    push_wr(8'h00, d[0]); model_write(254, 8'h00, d[0]);
    push_wr(8'h00, d[1]); model_write(255, 8'h00, d[1]);
    send_cmd(3'b000, 6'd3, 30'h7F0);
    t = 0;
    while (!c3_p0_wr_underrun && t < 20) begin tick(); t++; end
    checks++;
    if (c3_p0_wr_underrun !== 1'b1) begin
      errors++; $display("FAIL underrun_pulse: wr_underrun=%b expected 1", c3_p0_wr_underrun);
    end
    tick();
    checks++;
    if (c3_p0_wr_error !== 1'b1 || c3_p0_wr_underrun !== 1'b1) begin
      errors++; $display("FAIL underrun_error: err=%b underrun=%b expected 1/1", c3_p0_wr_error, c3_p0_wr_underrun);
    end
    push_wr(8'h00, d[2]); model_write(0, 8'h00, d[2]);
    push_wr(8'h00, d[3]); model_write(1, 8'h00, d[3]);
    repeat (3) tick();
    checks++;
    if (c3_p0_wr_underrun !== 1'b0 || c3_p0_wr_empty !== 1'b1) begin
      errors++; $display("FAIL underrun_resume: underrun=%b wr_empty=%b expected 0/1", c3_p0_wr_underrun, c3_p0_wr_empty);
    end
    expect_read(254, 4);
    send_cmd(3'b001, 6'd3, 30'h7F0);
    drain(4, "wrap");
  endtask

  initial begin
    test_reset();
    test_calib();
    test_burst();
    test_masked();
    test_errors_backpressure();
    test_reset_midread();
    test_underrun_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
